axis_ask_frame_tx: RTL and testbench

Packet framer that sits directly upstream of the ASK UART TX wrapper. It accepts one AXI-Stream byte packet (delimited by tlast) into an internal buffer. It then emits a framed byte stream: preamble, sync word, length, payload and CRC-8. Its m_* port connects straight to the TX wrapper's i_tdata/i_tvalid/i_tready. Single-buffered: input is stalled while a frame is being sent.

---
 rtl/ask_frame_pkg.sv | 28 ++
 rtl/axis_ask_frame_tx_if.sv | 10 +
 rtl/ask_frame_buf.sv | 27 ++
 rtl/axis_ask_frame_tx.sv | 188 ++++++++++++++++++
 tb/tb_axis_ask_frame_tx.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ask_frame_pkg.sv
// Shared definitions for the ASK framer/deframer pair: state encoding,
// framing constants and the CRC-8 (poly 0x07, MSB-first) byte update.
package ask_frame_pkg;

  typedef enum logic [2:0] {
    FILL,
    DROP,
    PRE,
    SYNC_H,
    SYNC_L,
    LEN,
    PAY,
    CRC
  } frame_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] CRC_POLY      = 8'h07;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_ask_frame_tx_if.sv
// Byte-wide AXI-Stream link used on both sides of the framer.
interface axis_ask_frame_tx_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ask_frame_buf.sv
// Payload buffer: one write port, one registered read port. Addresses at or
// beyond DEPTH are ignored so the caller may run its pointer one past the end.
module ask_frame_buf #(
  parameter int unsigned DEPTH = 64
) (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0]  DEPTH_W = 9'(DEPTH);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH_W)) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
    if ({1'b0, raddr} < DEPTH_W) begin
      rdata <= mem[raddr[AW-1:0]];
    end
  end

endmodule

// File: rtl/axis_ask_frame_tx.sv
// Packet framer ahead of the ASK UART TX wrapper: buffers one AXIS packet and
// emits preamble, sync word, length, payload and CRC-8 without bubbles.
module axis_ask_frame_tx
  import ask_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 64,
  parameter int unsigned PREAMBLE_LEN = 4,
  parameter logic [15:0] SYNC_WORD    = 16'hD391,
  parameter logic [7:0]  CRC_INIT     = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  axis_ask_frame_tx_if.slave  s,
  axis_ask_frame_tx_if.master m,
  output logic                busy,
  output logic                err_oversize
);
  localparam logic [8:0] MAX_CNT  = 9'(MAX_LEN);
  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN);

  frame_state_t state_q, state_n;
  logic [8:0]   cnt_q, cnt_n;
  logic [7:0]   len_q, len_n;
  logic [7:0]   crc_q, crc_n;
  logic [3:0]   pre_q, pre_n;
  logic [7:0]   rd_ptr_q, rd_ptr_n;
  logic [7:0]   tdata_q, tdata_n;
  logic         tvalid_q, tvalid_n;
  logic         s_tready_q, s_tready_n;
  logic         busy_q, busy_n;
  logic         err_q, err_n;

  logic         buf_we;
  logic [7:0]   buf_rdata;
  logic         s_hs, m_hs;

  assign s_hs         = s.tvalid & s_tready_q;
  assign m_hs         = tvalid_q & m.tready;
  assign s.tready     = s_tready_q;
  assign m.tdata      = tdata_q;
  assign m.tvalid     = tvalid_q;
  assign m.tlast      = 1'b0;
  assign busy         = busy_q;
  assign err_oversize = err_q;

  // Read address is the next-cycle pointer, so buf_rdata always holds the
  // byte that follows the one currently presented on m.
  ask_frame_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (cnt_q[7:0]),
    .wdata (s.tdata),
    .raddr (rd_ptr_n),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    len_n      = len_q;
    crc_n      = crc_q;
    pre_n      = pre_q;
    rd_ptr_n   = '0;
    tdata_n    = tdata_q;
    tvalid_n   = tvalid_q;
    s_tready_n = s_tready_q;
    busy_n     = busy_q;
    err_n      = 1'b0;
    buf_we     = 1'b0;

    unique case (state_q)
      FILL: begin
        if (s_hs) begin
          buf_we = (cnt_q < MAX_CNT);
          crc_n  = crc8_byte(crc_q, s.tdata);
          cnt_n  = cnt_q + 9'd1;
          if (s.tlast) begin
            if (cnt_q < MAX_CNT) begin
              len_n      = cnt_q[7:0] + 8'd1;
              state_n    = PRE;
              tvalid_n   = 1'b1;
              tdata_n    = PREAMBLE_BYTE;
              pre_n      = 4'd1;
              s_tready_n = 1'b0;
              busy_n     = 1'b1;
            end else begin
              err_n = 1'b1;
              cnt_n = '0;
              crc_n = CRC_INIT;
            end
          end else if (cnt_q == MAX_CNT) begin
            state_n = DROP;
          end
        end
      end
      DROP: begin
        if (s_hs && s.tlast) begin
          err_n   = 1'b1;
          cnt_n   = '0;
          crc_n   = CRC_INIT;
          state_n = FILL;
        end
      end
      PRE: begin
        if (m_hs) begin
          if (pre_q == PRE_LAST) begin
            state_n = SYNC_H;
            tdata_n = SYNC_WORD[15:8];
          end else begin
            pre_n = pre_q + 4'd1;
          end
        end
      end
      SYNC_H: begin
        if (m_hs) begin
          state_n = SYNC_L;
          tdata_n = SYNC_WORD[7:0];
        end
      end
      SYNC_L: begin
        if (m_hs) begin
          state_n = LEN;
          tdata_n = len_q;
        end
      end
      LEN: begin
        if (m_hs) begin
          state_n  = PAY;
          tdata_n  = buf_rdata;
          rd_ptr_n = 8'd1;
        end
      end
      PAY: begin
        rd_ptr_n = rd_ptr_q;
        if (m_hs) begin
          if (rd_ptr_q == len_q) begin
            state_n = CRC;
            tdata_n = crc_q;
          end else begin
            tdata_n  = buf_rdata;
            rd_ptr_n = rd_ptr_q + 8'd1;
          end
        end
      end
      CRC: begin
        if (m_hs) begin
          state_n    = FILL;
          tvalid_n   = 1'b0;
          tdata_n    = '0;
          cnt_n      = '0;
          crc_n      = CRC_INIT;
          s_tready_n = 1'b1;
          busy_n     = 1'b0;
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      len_q      <= '0;
      crc_q      <= CRC_INIT;
      pre_q      <= '0;
      rd_ptr_q   <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      s_tready_q <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      len_q      <= len_n;
      crc_q      <= crc_n;
      pre_q      <= pre_n;
      rd_ptr_q   <= rd_ptr_n;
      tdata_q    <= tdata_n;
      tvalid_q   <= tvalid_n;
      s_tready_q <= s_tready_n;
      busy_q     <= busy_n;
      err_q      <= err_n;
    end
  end

endmodule

// File: tb/tb_axis_ask_frame_tx.sv
// Directed bench for axis_ask_frame_tx: framing, max length, oversize drop,
// back-to-back packets and asynchronous reset mid-frame.
module tb_axis_ask_frame_tx;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, err_oversize;

  always #5 clk = ~clk;

  axis_ask_frame_tx_if s_if ();
  axis_ask_frame_tx_if m_if ();

  axis_ask_frame_tx #(
    .MAX_LEN      (64),
    .PREAMBLE_LEN (4),
    .SYNC_WORD    (16'hD391),
    .CRC_INIT     (8'h00)
  ) dut (
    .clk          (clk),
    .rst          (rst_n),
    .s            (s_if),
    .m            (m_if),
    .busy         (busy),
    .err_oversize (err_oversize)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] pkt [256];
  int         pkt_n;
  logic [7:0] exp_q [$];
  logic [7:0] rx [300];
  int         rx_cyc [300];
  int         rx_n;
  int         stab_err, busy_low, srdy_hi;
  int         err_seen, mv_seen, stall_seen;

  logic [7:0] e1 [9] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'hD3, 8'h91, 8'h01, 8'hA5, 8'h72};
  logic [7:0] e3 [10] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'hD3, 8'h91, 8'h02, 8'h12, 8'h34, 8'hF1};

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bit-serial CRC reference (LFSR form, feedback = crc msb xor data bit).
  function automatic logic [7:0] ref_crc(input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ pkt[i][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic build_exp();
    exp_q.delete();
    repeat (4) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD3);
    exp_q.push_back(8'h91);
    exp_q.push_back(8'(pkt_n));
    for (int i = 0; i < pkt_n; i++) exp_q.push_back(pkt[i]);
    exp_q.push_back(ref_crc(pkt_n));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (err_oversize === 1'b1) err_seen++;
    if (m_if.tvalid === 1'b1) mv_seen++;
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pkt_n; i++) begin
      int g;
      s_if.tdata  = pkt[i];
      s_if.tvalid = 1'b1;
      s_if.tlast  = (i == pkt_n - 1);
      g = 0;
      while (s_if.tready !== 1'b1 && g < 2000) begin
        stall_seen++;
        step();
        g++;
      end
      if (g >= 2000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout byte %0d: s_tready stayed low, required 1", i);
      end
      step();
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic collect(input int nbytes, input bit rnd);
    logic       prev_stall;
    logic [7:0] prev_d;
    int         cyc;
    prev_stall = 1'b0;
    prev_d     = '0;
    cyc        = 0;
    rx_n       = 0;
    stab_err   = 0;
    busy_low   = 0;
    srdy_hi    = 0;
    while (rx_n < nbytes && cyc < 3000) begin
      if (prev_stall && (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_d)) stab_err++;
      m_if.tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (m_if.tvalid === 1'b1 && busy !== 1'b1) busy_low++;
      if (s_if.tready !== 1'b0) srdy_hi++;
      prev_stall = (m_if.tvalid === 1'b1) && !m_if.tready;
      prev_d     = m_if.tdata;
      if (m_if.tvalid === 1'b1 && m_if.tready) begin
        rx[rx_n]     = m_if.tdata;
        rx_cyc[rx_n] = cyc;
        rx_n++;
      end
      step();
      cyc++;
    end
    m_if.tready = 1'b0;
    if (rx_n < nbytes) begin
      n_cmp++;
      n_bad++;
      $display("FAIL collect_timeout: got %0d bytes, required %0d", rx_n, nbytes);
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (s_if.tready !== 1'b1) begin n_bad++; $display("FAIL rst_s_tready: got %b, required 1", s_if.tready); end
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_m_tvalid: got %b, required 0", m_if.tvalid); end
    n_cmp++; if (m_if.tdata !== 8'h00) begin n_bad++; $display("FAIL rst_m_tdata: got %h, required 00", m_if.tdata); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_cmp++; if (err_oversize !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b, required 0", err_oversize); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_single_byte();
    pkt[0] = 8'hA5;
    pkt_n  = 1;
    send_pkt();
    collect(9, 1'b0);
    for (int k = 0; k < 9; k++) begin
      n_cmp++; if (rx[k] !== e1[k]) begin n_bad++; $display("FAIL t1_byte%0d: got %h, required %h", k, rx[k], e1[k]); end
      n_cmp++; if (rx_cyc[k] !== k) begin n_bad++; $display("FAIL t1_cycle%0d: got %0d, required %0d", k, rx_cyc[k], k); end
    end
    n_cmp++; if (busy_low !== 0) begin n_bad++; $display("FAIL t1_busy: busy low on %0d cycles, required 0", busy_low); end
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL t1_tvalid_end: got %b, required 0", m_if.tvalid); end
    n_cmp++; if (s_if.tready !== 1'b1) begin n_bad++; $display("FAIL t1_tready_end: got %b, required 1", s_if.tready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t1_busy_end: got %b, required 0", busy); end
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 64; i++) pkt[i] = 8'(i);
    pkt_n = 64;
    build_exp();
    send_pkt();
    collect(exp_q.size(), 1'b1);
    n_cmp++; if (rx_n !== exp_q.size()) begin n_bad++; $display("FAIL t2_count: got %0d, required %0d", rx_n, exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_cmp++; if (rx[k] !== exp_q[k]) begin n_bad++; $display("FAIL t2_byte%0d: got %h, required %h", k, rx[k], exp_q[k]); end
    end
    n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL t2_stable: %0d unstable stalls, required 0", stab_err); end
    n_cmp++; if (busy_low !== 0) begin n_bad++; $display("FAIL t2_busy: busy low on %0d cycles, required 0", busy_low); end
  endtask

  task automatic test_oversize();
    // 65 bytes with tlast on the 65th, then 70 bytes (passes through DROP)
    for (int pass = 0; pass < 2; pass++) begin
      pkt_n = (pass == 0) ? 65 : 70;
      for (int i = 0; i < pkt_n; i++) pkt[i] = 8'(8'hC0 ^ i);
      err_seen   = 0;
      mv_seen    = 0;
      stall_seen = 0;
      send_pkt();
      repeat (5) step();
      n_cmp++; if (err_seen !== 1) begin n_bad++; $display("FAIL t3_err_pulses_%0d: got %0d, required 1", pkt_n, err_seen); end
      n_cmp++; if (mv_seen !== 0) begin n_bad++; $display("FAIL t3_no_output_%0d: tvalid on %0d cycles, required 0", pkt_n, mv_seen); end
      n_cmp++; if (stall_seen !== 0) begin n_bad++; $display("FAIL t3_tready_%0d: %0d stall cycles, required 0", pkt_n, stall_seen); end
    end
    pkt[0] = 8'h12;
    pkt[1] = 8'h34;
    pkt_n  = 2;
    send_pkt();
    collect(10, 1'b0);
    for (int k = 0; k < 10; k++) begin
      n_cmp++; if (rx[k] !== e3[k]) begin n_bad++; $display("FAIL t3_byte%0d: got %h, required %h", k, rx[k], e3[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    int         srdy_a;
    logic       srdy_after;
    logic [7:0] rx_a [300];
    int         rx_a_n;
    pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h03;
    pkt_n  = 3;
    build_exp();
    exp_a = exp_q;
    send_pkt();
    pkt[0] = 8'hC3; pkt[1] = 8'h3C;
    pkt_n  = 2;
    build_exp();
    exp_b = exp_q;
    fork
      send_pkt();
      begin
        collect(exp_a.size(), 1'b0);
        srdy_a     = srdy_hi;
        srdy_after = s_if.tready;
        rx_a_n     = rx_n;
        for (int k = 0; k < rx_n; k++) rx_a[k] = rx[k];
      end
    join
    n_cmp++; if (srdy_a !== 0) begin n_bad++; $display("FAIL t4_tready_low: s_tready high on %0d cycles, required 0", srdy_a); end
    n_cmp++; if (srdy_after !== 1'b1) begin n_bad++; $display("FAIL t4_tready_rearm: got %b, required 1", srdy_after); end
    n_cmp++; if (rx_a_n !== exp_a.size()) begin n_bad++; $display("FAIL t4_a_count: got %0d, required %0d", rx_a_n, exp_a.size()); end
    for (int k = 0; k < exp_a.size(); k++) begin
      n_cmp++; if (rx_a[k] !== exp_a[k]) begin n_bad++; $display("FAIL t4_a_byte%0d: got %h, required %h", k, rx_a[k], exp_a[k]); end
    end
    collect(exp_b.size(), 1'b0);
    for (int k = 0; k < exp_b.size(); k++) begin
      n_cmp++; if (rx[k] !== exp_b[k]) begin n_bad++; $display("FAIL t4_b_byte%0d: got %h, required %h", k, rx[k], exp_b[k]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 8; i++) pkt[i] = 8'(8'h10 + i);
    pkt_n = 8;
    send_pkt();
    collect(10, 1'b0);
    m_if.tready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL t5_tvalid_async: got %b, required 0", m_if.tvalid); end
    n_cmp++; if (s_if.tready !== 1'b1) begin n_bad++; $display("FAIL t5_tready_async: got %b, required 1", s_if.tready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t5_busy_async: got %b, required 0", busy); end
    m_if.tready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    pkt[0] = 8'hA5;
    pkt_n  = 1;
    send_pkt();
    collect(9, 1'b0);
    for (int k = 0; k < 9; k++) begin
      n_cmp++; if (rx[k] !== e1[k]) begin n_bad++; $display("FAIL t5_byte%0d: got %h, required %h", k, rx[k], e1[k]); end
      n_cmp++; if (rx_cyc[k] !== k) begin n_bad++; $display("FAIL t5_cycle%0d: got %0d, required %0d", k, rx_cyc[k], k); end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_max_len();
    test_oversize();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
